// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame engine: FSM state encoding,
// parity-type constants, the stop-bit counter width and a parity helper.
package uart_tx_pkg;

  // Frame sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  // PAR_TYP encoding
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // One bit is enough to tell the first stop bit from the second
  localparam int STOP_CNT_W = 1;

  // Widest data word the engine supports
  localparam int MAX_DATA_WIDTH = 9;

  // Parity bit for a word (zero-extended to MAX_DATA_WIDTH; padding does not
  // change the XOR). Even: XOR of the data. Odd: its inverse.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] d,
                                       input logic                      typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_frame_bit_timer.sv
// Bit-period timer: counts TICK pulses 0..PRESCALE-1 while enabled and raises
// bit_end on the TICK that completes a bit period. A clear (frame acceptance)
// or reset returns the count to zero.
module uart_tx_bit_timer #(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  // The bit ends on the last TICK of the period; clear has priority
  assign bit_end = enable && tick && !clear && (cnt_q == LAST);

  // Tick counter: wraps at PRESCALE-1, holds on non-TICK cycles
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && tick) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start, DATA_WIDTH data bits LSB first, optional
// parity, then one stop bit (or two when built with UART_TX_STOP2_EN and
// STOP2=1 at acceptance). TX_OUT is a register; all frame options are latched
// when the word is accepted.
//
// Handshake: DATA_VALID is sampled only while BUSY=0 (state IDLE); a request
// seen there is accepted on that edge and BUSY rises the next cycle. Requests
// while BUSY=1 are dropped, not queued.
//
// Build option: UART_TX_STOP2_EN enables the two-stop-bit feature.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output uart_tx_state_t        STATE_DBG
);

  localparam int                IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0]     LAST_IDX = IW'(DATA_WIDTH - 1);

  uart_tx_state_t        state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_q, par_d;
  logic                  paren_q, paren_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  bit_end;

`ifdef UART_TX_STOP2_EN
  logic                  stop2_q, stop2_d;
  logic [STOP_CNT_W-1:0] stop_cnt_q, stop_cnt_d;
`else
  logic                  unused_stop2;
  assign unused_stop2 = STOP2;
`endif

  uart_tx_bit_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .tick    (TICK),
    .clear   (accept),
    .enable  (state_q != ST_IDLE),
    .bit_end (bit_end)
  );

  assign TX_OUT     = tx_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign FRAME_DONE = done_q;
  assign STATE_DBG  = state_q;

  // Next-state, latched frame options and registered line value
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    paren_d = paren_q;
    done_d  = 1'b0;
    accept  = 1'b0;
`ifdef UART_TX_STOP2_EN
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (DATA_VALID) begin
          accept  = 1'b1;
          data_d  = P_DATA;
          paren_d = PAR_EN;
          par_d   = calc_parity(MAX_DATA_WIDTH'(P_DATA), PAR_TYP);
          idx_d   = '0;
          state_d = ST_START;
`ifdef UART_TX_STOP2_EN
          stop2_d    = STOP2;
          stop_cnt_d = '0;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d = paren_q ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
`ifdef UART_TX_STOP2_EN
          if (stop2_q && (stop_cnt_q == '0)) begin
            stop_cnt_d = STOP_CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line value for the state being entered, so TX_OUT is a plain flop
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[idx_d];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      paren_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q    <= 1'b0;
      stop_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      paren_q <= paren_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_STOP2_EN
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame. Instance a: PRESCALE=1 with TICK every
// cycle. Instance b: PRESCALE=16 with TICK every fourth cycle.
// Inputs are driven and outputs sampled at the falling edge.
module tb_uart_tx_frame;
  import uart_tx_pkg::*;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [7:0]     P_DATA = '0;
  logic           PAR_EN = 1'b0;
  logic           PAR_TYP = 1'b0;
  logic           STOP2 = 1'b0;

  logic           a_tick = 1'b1;
  logic           a_valid = 1'b0;
  logic           a_tx, a_busy, a_done;
  uart_tx_state_t a_state;

  logic           b_tick = 1'b0;
  logic           b_valid = 1'b0;
  logic           b_tx, b_busy, b_done;
  uart_tx_state_t b_state;

  int checks = 0;
  int errors = 0;

  // Clock / reset
  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(1)) dut_a (
    .CLK(CLK), .RST(RST), .TICK(a_tick), .P_DATA(P_DATA), .DATA_VALID(a_valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(a_tx), .BUSY(a_busy), .FRAME_DONE(a_done), .STATE_DBG(a_state)
  );

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE(16)) dut_b (
    .CLK(CLK), .RST(RST), .TICK(b_tick), .P_DATA(P_DATA), .DATA_VALID(b_valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .TX_OUT(b_tx), .BUSY(b_busy), .FRAME_DONE(b_done), .STATE_DBG(b_state)
  );

  // TICK for instance b: one pulse every 4 cycles
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge CLK);
      ph = (ph + 1) % 4;
      b_tick = (ph == 0);
    end
  end

  // Driver: send one word on instance a and capture the frame. Bit i of
  // bits is the i-th line value seen while BUSY. inj >= 0 pulses a second
  // request (0x3C with parity enabled) at that cycle of the window.
  task automatic run_a(input logic [7:0] d, input logic pe, input logic pt,
                       input logic s2, input int inj,
                       output logic [15:0] bits, output int nbusy, output int ndone);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; a_valid = 1'b1;
    @(negedge CLK);
    a_valid = 1'b0;
    bits = '0; nbusy = 0; ndone = 0;
    for (int c = 0; c < 24; c++) begin
      if (a_busy) begin
        if (nbusy < 16) bits[nbusy] = a_tx;
        nbusy++;
      end
      if (a_done) ndone++;
      if (c == inj) begin
        P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1; a_valid = 1'b1;
      end else begin
        a_valid = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (a_tx !== 1'b1) begin errors++; $display("FAIL reset_a_tx got %b want 1", a_tx); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_a_done got %b want 0", a_done); end
    checks++; if (a_state !== ST_IDLE) begin errors++; $display("FAIL reset_a_state got %0d want %0d", a_state, ST_IDLE); end
    checks++; if (b_tx !== 1'b1) begin errors++; $display("FAIL reset_b_tx got %b want 1", b_tx); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy got %b want 0", b_busy); end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic_a5();
    logic [15:0] bits; int nb, nd;
    run_a(8'hA5, 1'b0, 1'b0, 1'b0, -1, bits, nb, nd);
    checks++; if (bits !== 16'h034A) begin errors++; $display("FAIL a5_bits got %h want 034a", bits); end
    checks++; if (nb !== 10) begin errors++; $display("FAIL a5_busy_cycles got %0d want 10", nb); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL a5_done_pulses got %0d want 1", nd); end
  endtask

  task automatic test_parity();
    logic [15:0] bits; int nb, nd;
    run_a(8'h07, 1'b1, PAR_EVEN, 1'b0, -1, bits, nb, nd);
    checks++; if (bits !== 16'h060E) begin errors++; $display("FAIL par_even_bits got %h want 060e", bits); end
    checks++; if (nb !== 11) begin errors++; $display("FAIL par_even_len got %0d want 11", nb); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL par_even_done got %0d want 1", nd); end
    run_a(8'h07, 1'b1, PAR_ODD, 1'b0, -1, bits, nb, nd);
    checks++; if (bits !== 16'h040E) begin errors++; $display("FAIL par_odd_bits got %h want 040e", bits); end
    checks++; if (nb !== 11) begin errors++; $display("FAIL par_odd_len got %0d want 11", nb); end
  endtask

  task automatic test_stop2();
    logic [15:0] bits; int nb, nd;
    run_a(8'hFF, 1'b0, 1'b0, 1'b1, -1, bits, nb, nd);
`ifdef UART_TX_STOP2_EN
    checks++; if (bits !== 16'h07FE) begin errors++; $display("FAIL stop2_bits got %h want 07fe", bits); end
    checks++; if (nb !== 11) begin errors++; $display("FAIL stop2_len got %0d want 11", nb); end
`else
    checks++; if (bits !== 16'h03FE) begin errors++; $display("FAIL stop2_bits got %h want 03fe", bits); end
    checks++; if (nb !== 10) begin errors++; $display("FAIL stop2_len got %0d want 10", nb); end
`endif
    checks++; if (nd !== 1) begin errors++; $display("FAIL stop2_done got %0d want 1", nd); end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] bits; int nb, nd;
    run_a(8'h81, 1'b0, 1'b0, 1'b0, 4, bits, nb, nd);
    checks++; if (bits !== 16'h0302) begin errors++; $display("FAIL ignore_bits got %h want 0302", bits); end
    checks++; if (nb !== 10) begin errors++; $display("FAIL ignore_len got %0d want 10", nb); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL ignore_done got %0d want 1", nd); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL ignore_idle_after got %b want 0", a_busy); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] bits; int nb, nd;
    @(negedge CLK);
    P_DATA = 8'h81; PAR_EN = 1'b0; STOP2 = 1'b0; a_valid = 1'b1;
    @(negedge CLK);
    a_valid = 1'b0;
    repeat (4) @(negedge CLK);
    checks++; if (a_state !== ST_DATA) begin errors++; $display("FAIL rstmid_in_data got %0d want %0d", a_state, ST_DATA); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (a_tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", a_tx); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", a_done); end
    RST = 1'b1;
    @(negedge CLK);
    run_a(8'hA5, 1'b0, 1'b0, 1'b0, -1, bits, nb, nd);
    checks++; if (bits !== 16'h034A) begin errors++; $display("FAIL rstmid_after_bits got %h want 034a", bits); end
    checks++; if (nb !== 10) begin errors++; $display("FAIL rstmid_after_len got %0d want 10", nb); end
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    @(negedge CLK);
    P_DATA = 8'hA5; PAR_EN = 1'b0; STOP2 = 1'b0; a_valid = 1'b1;
    for (int c = 0; c < 40 && seen == 0; c++) begin
      @(negedge CLK);
      if (a_done) seen = 1;
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL b2b_done_seen got %0d want 1", seen); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done got %b want 0", a_busy); end
    @(negedge CLK);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b want 1", a_busy); end
    checks++; if (a_tx !== 1'b0) begin errors++; $display("FAIL b2b_restart_tx got %b want 0", a_tx); end
    a_valid = 1'b0;
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_prescale16();
    int n_start, n_data, n_par, n_stop, n_low, seen;
    n_start = 0; n_data = 0; n_par = 0; n_stop = 0; n_low = 0; seen = 0;
    @(negedge CLK);
    P_DATA = 8'h00; PAR_EN = 1'b0; STOP2 = 1'b0; b_valid = 1'b1;
    @(negedge CLK);
    b_valid = 1'b0;
    checks++; if (b_tx !== 1'b0) begin errors++; $display("FAIL p16_first_tx got %b want 0", b_tx); end
    for (int c = 0; c < 1000 && seen == 0; c++) begin
      if (b_done) seen = 1;
      else begin
        if (b_state == ST_START)  n_start++;
        if (b_state == ST_DATA)   n_data++;
        if (b_state == ST_PARITY) n_par++;
        if (b_state == ST_STOP)   n_stop++;
        if (b_tx == 1'b0)         n_low++;
        @(negedge CLK);
      end
    end
    checks++; if (seen !== 1) begin errors++; $display("FAIL p16_done_seen got %0d want 1", seen); end
    checks++; if (n_data !== 512) begin errors++; $display("FAIL p16_data_cycles got %0d want 512", n_data); end
    checks++; if (n_stop !== 64) begin errors++; $display("FAIL p16_stop_cycles got %0d want 64", n_stop); end
    checks++; if (n_par !== 0) begin errors++; $display("FAIL p16_parity_cycles got %0d want 0", n_par); end
    checks++; if (n_start < 1 || n_start > 64) begin errors++; $display("FAIL p16_start_cycles got %0d want 1..64", n_start); end
    checks++; if (n_low !== n_start + 512) begin errors++; $display("FAIL p16_low_cycles got %0d want %0d", n_low, n_start + 512); end
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_parity();
    test_stop2();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_prescale16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
